// File: rtl/passthrough_queue_if.sv
// Ready/valid handshake bundle for passthrough_queue: enqueue side, dequeue side,
// flush and occupancy. master = producer/consumer environment, slave = the queue.
interface passthrough_queue_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_bits;
  logic             io_flush;
  logic [CNT_W-1:0] io_count;

  modport master (
    output io_enq_valid, io_enq_bits, io_deq_ready, io_flush,
    input  io_enq_ready, io_deq_valid, io_deq_bits, io_count
  );

  modport slave (
    input  io_enq_valid, io_enq_bits, io_deq_ready, io_flush,
    output io_enq_ready, io_deq_valid, io_deq_bits, io_count
  );
endinterface

// File: rtl/passthrough_queue.sv
// DEPTH-entry circular ready/valid queue with occupancy count, synchronous flush and
// optional zero-latency bypass (FLOW) when empty.
module passthrough_queue #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  parameter bit          FLOW  = 1'b0
) (
  input logic               clock,
  input logic               reset,
  passthrough_queue_if.slave io
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] enq_ptr, deq_ptr;
  logic             maybe_full;

  logic ptr_match, empty, full;
  logic do_enq, do_deq, bypass, wr_en, rd_adv;
  logic [CNT_W-1:0] count;

  // Explicit compare-and-clear so wrap is correct for non-power-of-two DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  always_comb begin
    io.io_enq_ready = ~full & ~io.io_flush;
    if (FLOW) begin
      io.io_deq_valid = (~empty | io.io_enq_valid) & ~io.io_flush;
      io.io_deq_bits  = empty ? io.io_enq_bits : storage[deq_ptr];
    end else begin
      io.io_deq_valid = ~empty & ~io.io_flush;
      io.io_deq_bits  = storage[deq_ptr];
    end
  end

  assign do_enq = io.io_enq_valid & io.io_enq_ready;
  assign do_deq = io.io_deq_valid & io.io_deq_ready;
  // A bypassed word never touches storage, pointers or the full flag.
  assign bypass = FLOW & empty & do_enq & do_deq;
  assign wr_en  = do_enq & ~bypass;
  assign rd_adv = do_deq & ~bypass;

  always_comb begin
    if (full) begin
      count = CNT_W'(DEPTH);
    end else if (enq_ptr >= deq_ptr) begin
      count = CNT_W'(enq_ptr - deq_ptr);
    end else begin
      count = CNT_W'(DEPTH) - CNT_W'(deq_ptr) + CNT_W'(enq_ptr);
    end
  end
  assign io.io_count = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else if (io.io_flush) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en)           enq_ptr    <= ptr_inc(enq_ptr);
      if (rd_adv)          deq_ptr    <= ptr_inc(deq_ptr);
      if (wr_en != rd_adv) maybe_full <= wr_en;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) storage[enq_ptr] <= io.io_enq_bits;
  end
endmodule

// File: tb/tb_passthrough_queue.sv
// Self-checking bench for passthrough_queue: directed scenarios plus randomized traffic
// against a queue-based reference model, over several DEPTH/FLOW configurations.
module tb_passthrough_queue;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  passthrough_queue_if #(.WIDTH(10), .DEPTH(4)) if_d4 ();
  passthrough_queue_if #(.WIDTH(10), .DEPTH(3)) if_d3 ();
  passthrough_queue_if #(.WIDTH(10), .DEPTH(4)) if_f4 ();
  passthrough_queue_if #(.WIDTH(10), .DEPTH(2)) if_d2 ();

  passthrough_queue #(.WIDTH(10), .DEPTH(4), .FLOW(1'b0)) dut_d4 (
    .clock(clock), .reset(reset), .io(if_d4));
  passthrough_queue #(.WIDTH(10), .DEPTH(3), .FLOW(1'b0)) dut_d3 (
    .clock(clock), .reset(reset), .io(if_d3));
  passthrough_queue #(.WIDTH(10), .DEPTH(4), .FLOW(1'b1)) dut_f4 (
    .clock(clock), .reset(reset), .io(if_f4));
  passthrough_queue #(.WIDTH(10), .DEPTH(2), .FLOW(1'b0)) dut_d2 (
    .clock(clock), .reset(reset), .io(if_d2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (if_d4.io_enq_ready !== 1'b1) begin errors++;
      $display("FAIL reset_enq_ready: got %b expected 1", if_d4.io_enq_ready); end
    checks++; if (if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL reset_deq_valid: got %b expected 0", if_d4.io_deq_valid); end
    checks++; if (if_d4.io_count !== 3'd0) begin errors++;
      $display("FAIL reset_count: got %0d expected 0", if_d4.io_count); end
    tick();
    reset = 1'b1;
    if_d4.io_deq_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if_d4.io_enq_valid = 1'b1;
      if_d4.io_enq_bits  = 10'(i * 17);
      tick();
    end
    if_d4.io_enq_valid = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd3) begin errors++;
      $display("FAIL pre_reset_count: got %0d expected 3", if_d4.io_count); end
    reset = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd0) begin errors++;
      $display("FAIL async_reset_count: got %0d expected 0", if_d4.io_count); end
    checks++; if (if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL async_reset_deq_valid: got %b expected 0", if_d4.io_deq_valid); end
    checks++; if (if_d4.io_enq_ready !== 1'b1) begin errors++;
      $display("FAIL async_reset_enq_ready: got %b expected 1", if_d4.io_enq_ready); end
    tick();
    reset = 1'b1;
    if_d4.io_enq_valid = 1'b1;
    if_d4.io_enq_bits  = 10'h155;
    #1;
    checks++; if (if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL post_reset_latency: got %b expected 0", if_d4.io_deq_valid); end
    tick();
    if_d4.io_enq_valid = 1'b0;
    #1;
    checks++; if (if_d4.io_deq_valid !== 1'b1 || if_d4.io_deq_bits !== 10'h155) begin errors++;
      $display("FAIL post_reset_first_word: got v=%b d=%h expected v=1 d=155",
               if_d4.io_deq_valid, if_d4.io_deq_bits); end
    if_d4.io_deq_ready = 1'b1;
    tick();
    if_d4.io_deq_ready = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd0 || if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL post_reset_drain: got count=%0d v=%b expected 0/0",
               if_d4.io_count, if_d4.io_deq_valid); end
  endtask

  task automatic test_fill_drain();
    int stored = 0;
    logic [9:0] model[$];
    if_d4.io_deq_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if_d4.io_enq_valid = 1'b1;
      if_d4.io_enq_bits  = 10'(i);
      #1;
      checks++; if (if_d4.io_enq_ready !== (stored < 4)) begin errors++;
        $display("FAIL fill_enq_ready[%0d]: got %b expected %b", i, if_d4.io_enq_ready,
                 stored < 4); end
      if (stored < 4) begin model.push_back(10'(i)); stored++; end
      tick();
    end
    if_d4.io_enq_valid = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd4) begin errors++;
      $display("FAIL fill_count: got %0d expected 4", if_d4.io_count); end
    if_d4.io_deq_ready = 1'b1;
    while (model.size() > 0) begin
      logic [9:0] exp_w;
      exp_w = model.pop_front();
      #1;
      checks++; if (if_d4.io_deq_valid !== 1'b1 || if_d4.io_deq_bits !== exp_w) begin errors++;
        $display("FAIL drain_word: got v=%b d=%h expected v=1 d=%h", if_d4.io_deq_valid,
                 if_d4.io_deq_bits, exp_w); end
      tick();
    end
    #1;
    checks++; if (if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty: got %b expected 0", if_d4.io_deq_valid); end
    if_d4.io_deq_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [9:0] model[$];
    logic [9:0] pend = '0;
    bit pend_v = 0;
    int n_sent = 0, n_recv = 0, cyc = 0;
    bit exp_er, exp_dv, do_enq, do_deq;
    while (n_recv < 100 && cyc < 3000) begin
      if (!pend_v && n_sent < 100 && $urandom_range(0, 3) != 0) begin
        pend = 10'($urandom); pend_v = 1;
      end
      if_d3.io_enq_valid = pend_v;
      if_d3.io_enq_bits  = pend_v ? pend : 10'($urandom);
      if_d3.io_deq_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_er = model.size() < 3;
      exp_dv = model.size() > 0;
      checks++; if (if_d3.io_enq_ready !== exp_er || if_d3.io_deq_valid !== exp_dv ||
                    if_d3.io_count !== 2'(model.size())) begin errors++;
        $display("FAIL wrap_status cyc %0d: got er=%b dv=%b cnt=%0d expected %b %b %0d", cyc,
                 if_d3.io_enq_ready, if_d3.io_deq_valid, if_d3.io_count, exp_er, exp_dv,
                 model.size()); end
      if (exp_dv) begin
        checks++; if (if_d3.io_deq_bits !== model[0]) begin errors++;
          $display("FAIL wrap_order word %0d: got %h expected %h", n_recv,
                   if_d3.io_deq_bits, model[0]); end
      end
      do_deq = exp_dv && if_d3.io_deq_ready;
      do_enq = pend_v && exp_er;
      tick();
      if (do_deq) begin void'(model.pop_front()); n_recv++; end
      if (do_enq) begin model.push_back(pend); n_sent++; pend_v = 0; end
      cyc++;
    end
    if_d3.io_enq_valid = 1'b0;
    if_d3.io_deq_ready = 1'b0;
    checks++; if (n_recv != 100) begin errors++;
      $display("FAIL wrap_complete: got %0d words expected 100", n_recv); end
  endtask

  task automatic test_flow();
    logic [9:0] model[$];
    logic [9:0] pend = '0, exp_b;
    bit pend_v = 0, exp_dv, do_enq, do_deq;
    int n_sent = 0, n_recv = 0, cyc = 0;
    if_f4.io_enq_valid = 1'b1;
    if_f4.io_enq_bits  = 10'h2AA;
    if_f4.io_deq_ready = 1'b1;
    #1;
    checks++; if (if_f4.io_deq_valid !== 1'b1 || if_f4.io_deq_bits !== 10'h2AA) begin errors++;
      $display("FAIL flow_bypass: got v=%b d=%h expected v=1 d=2aa", if_f4.io_deq_valid,
               if_f4.io_deq_bits); end
    tick();
    if_f4.io_enq_valid = 1'b0;
    #1;
    checks++; if (if_f4.io_count !== 3'd0 || if_f4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL flow_bypass_nostore: got cnt=%0d v=%b expected 0/0", if_f4.io_count,
               if_f4.io_deq_valid); end
    while (n_recv < 60 && cyc < 2000) begin
      if (!pend_v && n_sent < 60 && $urandom_range(0, 2) != 0) begin
        pend = 10'($urandom); pend_v = 1;
      end
      if_f4.io_enq_valid = pend_v;
      if_f4.io_enq_bits  = pend_v ? pend : 10'($urandom);
      if_f4.io_deq_ready = ($urandom_range(0, 2) == 0);
      #1;
      exp_dv = (model.size() > 0) || pend_v;
      exp_b  = (model.size() > 0) ? model[0] : pend;
      checks++; if (if_f4.io_deq_valid !== exp_dv || if_f4.io_count !== 3'(model.size()))
      begin errors++;
        $display("FAIL flow_status cyc %0d: got dv=%b cnt=%0d expected %b %0d", cyc,
                 if_f4.io_deq_valid, if_f4.io_count, exp_dv, model.size()); end
      if (exp_dv) begin
        checks++; if (if_f4.io_deq_bits !== exp_b) begin errors++;
          $display("FAIL flow_order word %0d: got %h expected %h", n_recv,
                   if_f4.io_deq_bits, exp_b); end
      end
      do_deq = exp_dv && if_f4.io_deq_ready;
      do_enq = pend_v && model.size() < 4;
      tick();
      if (do_enq && do_deq && model.size() == 0) begin
        n_recv++;
      end else begin
        if (do_deq) begin void'(model.pop_front()); n_recv++; end
        if (do_enq) model.push_back(pend);
      end
      if (do_enq) begin n_sent++; pend_v = 0; end
      cyc++;
    end
    if_f4.io_enq_valid = 1'b0;
    if_f4.io_deq_ready = 1'b0;
    checks++; if (n_recv != 60) begin errors++;
      $display("FAIL flow_complete: got %0d words expected 60", n_recv); end
  endtask

  task automatic test_flush();
    if_d4.io_deq_ready = 1'b0;
    if_d4.io_enq_valid = 1'b1;
    if_d4.io_enq_bits  = 10'h0A1; tick();
    if_d4.io_enq_bits  = 10'h0A2; tick();
    if_d4.io_flush     = 1'b1;
    if_d4.io_enq_bits  = 10'h3FF;
    if_d4.io_deq_ready = 1'b1;
    #1;
    checks++; if (if_d4.io_enq_ready !== 1'b0 || if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL flush_cycle: got er=%b dv=%b expected 0/0", if_d4.io_enq_ready,
               if_d4.io_deq_valid); end
    tick();
    if_d4.io_flush     = 1'b0;
    if_d4.io_enq_valid = 1'b0;
    if_d4.io_deq_ready = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd0 || if_d4.io_deq_valid !== 1'b0) begin errors++;
      $display("FAIL flush_after: got cnt=%0d dv=%b expected 0/0", if_d4.io_count,
               if_d4.io_deq_valid); end
    if_d4.io_enq_valid = 1'b1;
    if_d4.io_enq_bits  = 10'h0B1;
    tick();
    if_d4.io_enq_valid = 1'b0;
    #1;
    checks++; if (if_d4.io_count !== 3'd1 || if_d4.io_deq_bits !== 10'h0B1) begin errors++;
      $display("FAIL flush_next_word: got cnt=%0d d=%h expected 1 0b1", if_d4.io_count,
               if_d4.io_deq_bits); end
    if_d4.io_deq_ready = 1'b1;
    tick();
    if_d4.io_deq_ready = 1'b0;
  endtask

  task automatic test_full_deq();
    if_d2.io_deq_ready = 1'b0;
    if_d2.io_enq_valid = 1'b1;
    if_d2.io_enq_bits  = 10'h0C1; tick();
    if_d2.io_enq_bits  = 10'h0C2; tick();
    if_d2.io_enq_bits  = 10'h0C3;
    if_d2.io_deq_ready = 1'b1;
    #1;
    checks++; if (if_d2.io_enq_ready !== 1'b0 || if_d2.io_deq_valid !== 1'b1 ||
                  if_d2.io_deq_bits !== 10'h0C1) begin errors++;
      $display("FAIL full_deq_cycle: got er=%b dv=%b d=%h expected 0 1 0c1",
               if_d2.io_enq_ready, if_d2.io_deq_valid, if_d2.io_deq_bits); end
    tick();
    if_d2.io_deq_ready = 1'b0;
    #1;
    checks++; if (if_d2.io_count !== 2'd1 || if_d2.io_enq_ready !== 1'b1) begin errors++;
      $display("FAIL full_deq_after: got cnt=%0d er=%b expected 1 1", if_d2.io_count,
               if_d2.io_enq_ready); end
    tick();
    if_d2.io_enq_valid = 1'b0;
    if_d2.io_deq_ready = 1'b1;
    #1;
    checks++; if (if_d2.io_count !== 2'd2 || if_d2.io_deq_bits !== 10'h0C2) begin errors++;
      $display("FAIL full_deq_accept: got cnt=%0d d=%h expected 2 0c2", if_d2.io_count,
               if_d2.io_deq_bits); end
    tick();
    #1;
    checks++; if (if_d2.io_deq_bits !== 10'h0C3) begin errors++;
      $display("FAIL full_deq_last: got %h expected 0c3", if_d2.io_deq_bits); end
    tick();
    if_d2.io_deq_ready = 1'b0;
  endtask

  initial begin
    if_d4.io_enq_valid = 0; if_d4.io_enq_bits = '0; if_d4.io_deq_ready = 0; if_d4.io_flush = 0;
    if_d3.io_enq_valid = 0; if_d3.io_enq_bits = '0; if_d3.io_deq_ready = 0; if_d3.io_flush = 0;
    if_f4.io_enq_valid = 0; if_f4.io_enq_bits = '0; if_f4.io_deq_ready = 0; if_f4.io_flush = 0;
    if_d2.io_enq_valid = 0; if_d2.io_enq_bits = '0; if_d2.io_deq_ready = 0; if_d2.io_flush = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flow();
    test_flush();
    test_full_deq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/passthrough_queue.md
Name: passthrough_queue

Overview:
Parametrised successor to the combinational passthrough: carries WIDTH-bit words from an input port to an output port through a DEPTH-entry buffer with ready/valid handshakes on both sides. It provides elasticity, back-pressure, an occupancy count and a synchronous flush. An optional flow mode gives zero-latency pass-through when the buffer is empty. It sits between any two decoupled pipeline stages.

Parameters:
WIDTH, 10, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=1, power of two not required)
FLOW, 0, 1 = combinational bypass from enq to deq when the buffer is empty; 0 = always registered
CNT_W, clog2(DEPTH+1), derived width of io_count; not overridden

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
io_enq_valid  input  1  producer presents a word
io_enq_ready  output  1  buffer accepts a word this cycle
io_enq_bits  input  WIDTH  producer word
io_deq_valid  output  1  word available to consumer
io_deq_ready  input  1  consumer accepts the word
io_deq_bits  output  WIDTH  head word
io_flush  input  1  synchronous clear of contents
io_count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- State: storage[DEPTH], enq_ptr, deq_ptr (0..DEPTH-1), maybe_full flag. Storage is not reset.
- Reset (reset=0, asynchronous, any time including mid-transfer): enq_ptr=deq_ptr=0, maybe_full=0, all contents discarded. While asserted and after release: io_enq_ready=1, io_deq_valid=0 (FLOW=0), io_count=0. io_deq_bits is don't-care while io_deq_valid=0.
- Derived signals:
  - empty = (enq_ptr==deq_ptr) & !maybe_full
  - full = (enq_ptr==deq_ptr) & maybe_full
- io_enq_ready = !full & !io_flush. A full buffer does not accept data even if io_deq_ready=1; there is no same-cycle pipe-through.
- io_deq_valid:
  - FLOW=0: !empty & !io_flush
  - FLOW=1: (!empty | io_enq_valid) & !io_flush
- io_deq_bits = storage[deq_ptr]. When FLOW=1 and empty, io_deq_bits = io_enq_bits.
- Handshakes: do_enq = io_enq_valid & io_enq_ready; do_deq = io_deq_valid & io_deq_ready. Valid must not depend combinationally on ready on either side. A producer holds bits stable while valid & !ready.
- On do_enq: storage[enq_ptr] <= io_enq_bits and enq_ptr advances.
- On do_deq: deq_ptr advances.
- Pointer wrap: DEPTH-1 -> 0. Must be correct for non-power-of-two DEPTH.
- maybe_full <= do_enq whenever do_enq != do_deq; otherwise it holds.
- Simultaneous enq+deq when neither empty nor full: both pointers advance, count unchanged.
- FLOW=1, empty, do_enq & do_deq: word passes straight through. No storage write, no pointer or flag change, count stays 0.
- FLOW=1, empty, do_enq & !do_deq: word is stored normally.
- io_count = full ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH. It is registered-state based, so it changes only on clock edges.
- Latency, enq to deq_valid:
  - FLOW=0: 1 cycle.
  - FLOW=1 and empty: 0 cycles.
  - Otherwise: word order is strict FIFO.
- Flush (io_flush=1, sampled at clock edge): next state is enq_ptr=deq_ptr=0, maybe_full=0. Ready and valid are forced low in the flush cycle, so no transfer occurs. Flush has priority over all handshakes.
- DEPTH=1: single-entry register. It alternates full/empty; full blocks enq even if deq_ready.

Test Plan:
- Reset: hold reset=0 mid-stream with 3 words stored -> io_count=0, io_deq_valid=0, io_enq_ready=1 immediately (async); after release the first enq of 0x155 appears on deq 1 cycle later (FLOW=0).
- Fill/drain: DEPTH=4, io_deq_ready=0, enq 0x001..0x005 -> first 4 accepted, io_enq_ready=0 after 4th, io_count=4; then io_deq_ready=1 -> deq 0x001,0x002,0x003,0x004 in order, then io_deq_valid=0.
- Wrap and concurrency: DEPTH=3 (non power of two), continuous enq/deq with random ready/valid for 100 words -> output sequence equals input sequence; io_count never exceeds 3; pointers wrap correctly.
- Flow mode: FLOW=1, empty, io_enq_valid=1 with bits 0x2AA, io_deq_ready=1 -> io_deq_valid=1 and io_deq_bits=0x2AA in the same cycle; io_count stays 0.
- Flush: 2 words stored, io_flush=1 with io_enq_valid=1 -> io_enq_ready=0 and io_deq_valid=0 that cycle; next cycle io_count=0, and the word offered during the flush is not stored.
- Full with deq: DEPTH=2 full, io_deq_ready=1, io_enq_valid=1 -> io_enq_ready=0 that cycle; one word dequeued, count=1; the enq is accepted the next cycle.
